// File: rtl/add8_pkg.sv
// Shared types and constants for the 8-bit sum accumulator stage.
package add8_pkg;

  localparam int SUM_W      = 8;
  localparam int N_SUMS_DEF = 4;
  localparam int OUT_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add8_beat_cnt.sv
// Beat counter: counts accepted words of one result and flags the last one.
module add8_beat_cnt #(
  parameter int N_SUMS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  input  logic inc,
  output logic tc
);

  localparam int CNT_W = $clog2(N_SUMS + 1);
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(N_SUMS - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(1);
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // tc marks that the word accepted this cycle completes the result
  assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/add8_sum_accum.sv
// Accumulates N_SUMS registered 8-bit sums into an OUT_W-bit total with valid/ready output.
module add8_sum_accum
  import add8_pkg::*;
#(
  parameter int N_SUMS = N_SUMS_DEF,
  parameter int OUT_W  = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [SUM_W-1:0] sum_in,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [OUT_W-1:0] acc_out,
  output logic             acc_ovf,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             busy
);

  localparam int AW = OUT_W + 1;

  state_t      state;
  state_t      state_nx;
  logic        accept;
  logic        take;
  logic        tc;
  logic [AW-1:0] sum_nx;

  function automatic logic [AW-1:0] acc_add(input logic [OUT_W-1:0] a,
                                            input logic [SUM_W-1:0] b);
    return {1'b0, a} + AW'(b);
  endfunction

  assign in_rdy  = (state != DONE) && !clr;
  assign accept  = in_vld && in_rdy;
  assign out_vld = (state == DONE);
  assign take    = out_vld && out_rdy;
  assign busy    = (state != IDLE);
  assign sum_nx  = acc_add(acc_out, sum_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (clr) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (accept) state_nx = (N_SUMS == 1) ? DONE : ACC;
        ACC:     if (accept && tc) state_nx = DONE;
        DONE:    if (out_rdy) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  add8_beat_cnt #(
    .N_SUMS(N_SUMS)
  ) u_beat_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr || take),
    .load (accept && (state == IDLE)),
    .inc  (accept && (state == ACC)),
    .tc   (tc)
  );

  // The result stays on acc_out after the take until the next first accept
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc_out <= '0;
      acc_ovf <= 1'b0;
    end else if (accept) begin
      if (state == IDLE) begin
        acc_out <= OUT_W'(sum_in);
        acc_ovf <= 1'b0;
      end else begin
        acc_out <= sum_nx[OUT_W-1:0];
        acc_ovf <= acc_ovf | sum_nx[OUT_W];
      end
    end
  end

endmodule
